// File: rtl/addition_control_unit.sv
// rtl/addition_control_unit.sv - sequencing FSM for the single-precision FP adder datapath
module addition_control_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int MENT_WIDTH = 23,
  parameter int EXPO_WIDTH = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  start_in,
  output logic                  ready_out,
  input  logic [EXPO_WIDTH:0]   exp_diff_in,
  input  logic [EXPO_WIDTH-1:0] bigger_exponent_in,
  input  logic                  signs_differ_in,
  output logic                  mux1_sel_out,
  output logic                  mux2_sel_out,
  output logic                  mux3_sel_out,
  output logic [EXPO_WIDTH-1:0] shift_amt_out,
  output logic                  shift_en_out,
  output logic                  add_en_out,
  output logic                  effective_sub_out,
  input  logic                  sum_carry_in,
  input  logic                  sum_msb_in,
  input  logic                  sum_zero_in,
  output logic                  norm_right_out,
  output logic                  norm_left_out,
  output logic [EXPO_WIDTH-1:0] result_exponent_out,
  output logic                  done_out,
  output logic                  overflow_out,
  output logic                  underflow_out,
  output logic                  zero_out,
  output logic                  special_out
);

  // Left-shift counter only has to reach MENT_WIDTH+1, which always fits in log2 of the word width.
  localparam int ITW = $clog2(DATA_WIDTH);
  localparam logic [ITW-1:0]        ITER_MAX  = ITW'(MENT_WIDTH + 1);
  localparam logic [EXPO_WIDTH:0]   SHIFT_CAP = (EXPO_WIDTH + 1)'(MENT_WIDTH + 2);
  localparam logic [EXPO_WIDTH-1:0] EXP_ONE   = EXPO_WIDTH'(1);
  localparam logic [EXPO_WIDTH-1:0] EXP_TOP   = {{(EXPO_WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    S_IDLE, S_COMPARE, S_ALIGN, S_ADD, S_NORM, S_DONE
  } state_t;

  state_t                r_state, w_next_state;
  logic                  r_sel, w_sel;
  logic [EXPO_WIDTH-1:0] r_shift_amt, w_shift_amt;
  logic                  r_shift_en, w_shift_en;
  logic                  r_add_en, w_add_en;
  logic                  r_eff_sub, w_eff_sub;
  logic                  r_norm_right, w_norm_right;
  logic                  r_norm_left, w_norm_left;
  logic [EXPO_WIDTH-1:0] r_exp, w_exp;
  logic                  r_done, w_done;
  logic                  r_ovf, w_ovf;
  logic                  r_unf, w_unf;
  logic                  r_zero, w_zero;
  logic                  r_special, w_special;
  logic [ITW-1:0]        r_iter, w_iter;

  logic                  w_ge;
  logic [EXPO_WIDTH:0]   w_mag;
  logic [EXPO_WIDTH-1:0] w_shift_capped;

  assign w_ge           = ~exp_diff_in[EXPO_WIDTH];
  assign w_mag          = w_ge ? exp_diff_in : (~exp_diff_in + 1'b1);
  assign w_shift_capped = (w_mag > SHIFT_CAP) ? SHIFT_CAP[EXPO_WIDTH-1:0] : w_mag[EXPO_WIDTH-1:0];

  always_comb begin
    w_next_state = r_state;
    w_sel        = r_sel;
    w_shift_amt  = r_shift_amt;
    w_eff_sub    = r_eff_sub;
    w_exp        = r_exp;
    w_iter       = r_iter;
    w_ovf        = r_ovf;
    w_unf        = r_unf;
    w_zero       = r_zero;
    w_special    = r_special;
    w_shift_en   = 1'b0;
    w_add_en     = 1'b0;
    w_norm_right = 1'b0;
    w_norm_left  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_in) begin
          w_next_state = S_COMPARE;
          w_ovf        = 1'b0;
          w_unf        = 1'b0;
          w_zero       = 1'b0;
          w_special    = 1'b0;
          w_iter       = '0;
        end
      end
      S_COMPARE: begin
        w_sel       = w_ge;
        w_shift_amt = w_shift_capped;
        w_exp       = bigger_exponent_in;
        w_eff_sub   = signs_differ_in;
        if (&bigger_exponent_in) begin
          w_special    = 1'b1;
          w_next_state = S_DONE;
        end else begin
          w_shift_en   = 1'b1;
          w_next_state = S_ALIGN;
        end
      end
      S_ALIGN: begin
        w_add_en     = 1'b1;
        w_next_state = S_ADD;
      end
      S_ADD: w_next_state = S_NORM;
      S_NORM: begin
        if (sum_zero_in) begin
          w_zero       = 1'b1;
          w_exp        = '0;
          w_next_state = S_DONE;
        end else if (sum_carry_in) begin
          if (r_exp == EXP_TOP) begin
            w_ovf = 1'b1;
            w_exp = '1;
          end else begin
            w_norm_right = 1'b1;
            w_exp        = r_exp + 1'b1;
          end
          w_next_state = S_DONE;
        end else if (sum_msb_in || (r_iter == ITER_MAX)) begin
          w_next_state = S_DONE;
        end else if (r_exp == EXP_ONE) begin
          w_unf        = 1'b1;
          w_next_state = S_DONE;
        end else begin
          w_norm_left = 1'b1;
          w_exp       = r_exp - 1'b1;
          w_iter      = r_iter + 1'b1;
        end
      end
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    w_done = (w_next_state == S_DONE) && (r_state != S_DONE);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state      <= S_IDLE;
      r_sel        <= 1'b0;
      r_shift_amt  <= '0;
      r_shift_en   <= 1'b0;
      r_add_en     <= 1'b0;
      r_eff_sub    <= 1'b0;
      r_norm_right <= 1'b0;
      r_norm_left  <= 1'b0;
      r_exp        <= '0;
      r_done       <= 1'b0;
      r_ovf        <= 1'b0;
      r_unf        <= 1'b0;
      r_zero       <= 1'b0;
      r_special    <= 1'b0;
      r_iter       <= '0;
    end else begin
      r_state      <= w_next_state;
      r_sel        <= w_sel;
      r_shift_amt  <= w_shift_amt;
      r_shift_en   <= w_shift_en;
      r_add_en     <= w_add_en;
      r_eff_sub    <= w_eff_sub;
      r_norm_right <= w_norm_right;
      r_norm_left  <= w_norm_left;
      r_exp        <= w_exp;
      r_done       <= w_done;
      r_ovf        <= w_ovf;
      r_unf        <= w_unf;
      r_zero       <= w_zero;
      r_special    <= w_special;
      r_iter       <= w_iter;
    end
  end

  assign ready_out           = (r_state == S_IDLE);
  assign mux1_sel_out        = r_sel;
  assign mux2_sel_out        = r_sel;
  assign mux3_sel_out        = r_sel;
  assign shift_amt_out       = r_shift_amt;
  assign shift_en_out        = r_shift_en;
  assign add_en_out          = r_add_en;
  assign effective_sub_out   = r_eff_sub;
  assign norm_right_out      = r_norm_right;
  assign norm_left_out       = r_norm_left;
  assign result_exponent_out = r_exp;
  assign done_out            = r_done;
  assign overflow_out        = r_ovf;
  assign underflow_out       = r_unf;
  assign zero_out            = r_zero;
  assign special_out         = r_special;

endmodule

// File: tb/tb_addition_control_unit.sv
// tb/tb_addition_control_unit.sv - table-driven and randomized bench for addition_control_unit
module tb_addition_control_unit;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       start_in;
  logic       ready_out;
  logic [8:0] exp_diff_in;
  logic [7:0] bigger_exponent_in;
  logic       signs_differ_in;
  logic       mux1_sel_out, mux2_sel_out, mux3_sel_out;
  logic [7:0] shift_amt_out;
  logic       shift_en_out, add_en_out, effective_sub_out;
  logic       sum_carry_in, sum_msb_in, sum_zero_in;
  logic       norm_right_out, norm_left_out;
  logic [7:0] result_exponent_out;
  logic       done_out, overflow_out, underflow_out, zero_out, special_out;

  int total = 0;
  int bad   = 0;

  addition_control_unit dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in), .ready_out(ready_out),
    .exp_diff_in(exp_diff_in), .bigger_exponent_in(bigger_exponent_in),
    .signs_differ_in(signs_differ_in),
    .mux1_sel_out(mux1_sel_out), .mux2_sel_out(mux2_sel_out), .mux3_sel_out(mux3_sel_out),
    .shift_amt_out(shift_amt_out), .shift_en_out(shift_en_out), .add_en_out(add_en_out),
    .effective_sub_out(effective_sub_out),
    .sum_carry_in(sum_carry_in), .sum_msb_in(sum_msb_in), .sum_zero_in(sum_zero_in),
    .norm_right_out(norm_right_out), .norm_left_out(norm_left_out),
    .result_exponent_out(result_exponent_out), .done_out(done_out),
    .overflow_out(overflow_out), .underflow_out(underflow_out),
    .zero_out(zero_out), .special_out(special_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [8:0] diff;
    logic [7:0] big;
    bit sdiff, carry, zero;
    int n_low;
    bit e_sel;
    int e_sham;
    bit e_sub;
    int e_rexp;
    bit e_ovf, e_unf, e_zf, e_spf;
    int e_lat, e_right, e_left, e_se;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [28:0] all_outs();
    return {mux1_sel_out, mux2_sel_out, mux3_sel_out, shift_amt_out, shift_en_out, add_en_out,
            effective_sub_out, norm_right_out, norm_left_out, result_exponent_out, done_out,
            overflow_out, underflow_out, zero_out, special_out};
  endfunction

  function automatic vec_t mk(logic [8:0] diff, logic [7:0] big, bit sdiff, bit carry, bit zero,
                              int n_low, bit sel, int sham, int rexp, bit ovf, bit unf, bit zf,
                              bit spf, int lat, int right, int left, int se);
    vec_t v;
    v.diff = diff; v.big = big; v.sdiff = sdiff; v.carry = carry; v.zero = zero; v.n_low = n_low;
    v.e_sel = sel; v.e_sham = sham; v.e_sub = sdiff; v.e_rexp = rexp;
    v.e_ovf = ovf; v.e_unf = unf; v.e_zf = zf; v.e_spf = spf;
    v.e_lat = lat; v.e_right = right; v.e_left = left; v.e_se = se;
    return v;
  endfunction

  // Reference: outcome of one addition computed directly from the exponent arithmetic.
  function automatic vec_t model(vec_t v);
    int d, mag, k;
    d   = int'($signed(v.diff));
    mag = (d < 0) ? -d : d;
    v.e_sel = (d >= 0);
    v.e_sham = (mag > 25) ? 25 : mag;
    v.e_sub = v.sdiff;
    v.e_ovf = 0; v.e_unf = 0; v.e_zf = 0; v.e_spf = 0;
    v.e_right = 0; v.e_left = 0; v.e_se = 1; v.e_lat = 5;
    if (v.big == 8'd255) begin
      v.e_spf = 1; v.e_rexp = 255; v.e_lat = 2; v.e_se = 0;
    end else if (v.zero) begin
      v.e_zf = 1; v.e_rexp = 0;
    end else if (v.carry) begin
      if (v.big == 8'd254) begin v.e_ovf = 1; v.e_rexp = 255; end
      else begin v.e_right = 1; v.e_rexp = int'(v.big) + 1; end
    end else begin
      k = v.n_low;
      if (k > 24) k = 24;
      if (k > int'(v.big) - 1) k = int'(v.big) - 1;
      v.e_left = k;
      v.e_rexp = int'(v.big) - k;
      v.e_lat  = 5 + k;
      v.e_unf  = (v.n_low > k) && (k < 24) && (k == int'(v.big) - 1);
    end
    return v;
  endfunction

  task automatic run_op(input vec_t v, input bit poke, input string tag);
    int done_cyc, n_done, n_se, n_ae, n_r, n_l;
    done_cyc = -1; n_done = 0; n_se = 0; n_ae = 0; n_r = 0; n_l = 0;
    @(posedge clk_in); #1;
    exp_diff_in = v.diff; bigger_exponent_in = v.big; signs_differ_in = v.sdiff;
    sum_carry_in = 0; sum_msb_in = 0; sum_zero_in = 0; start_in = 1;
    @(negedge clk_in);
    chk({tag, " ready_before"}, ready_out, 1);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk_in); #1;
      start_in = poke && (cyc == 3);
      if (cyc >= 4) begin
        sum_zero_in  = v.zero;
        sum_carry_in = v.carry;
        sum_msb_in   = ((cyc - 4) >= v.n_low);
      end
      @(negedge clk_in);
      if (done_out) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      n_se += int'(shift_en_out); n_ae += int'(add_en_out);
      n_r  += int'(norm_right_out); n_l += int'(norm_left_out);
      if (done_cyc >= 0 && cyc >= done_cyc + 8) break;
    end
    start_in = 0;
    chk({tag, " done_cycle"}, done_cyc, v.e_lat);
    chk({tag, " done_count"}, n_done, 1);
    chk({tag, " selects"}, {mux1_sel_out, mux2_sel_out, mux3_sel_out}, {3{v.e_sel}});
    chk({tag, " shift_amt"}, shift_amt_out, v.e_sham);
    chk({tag, " eff_sub"}, effective_sub_out, v.e_sub);
    chk({tag, " result_exp"}, result_exponent_out, v.e_rexp);
    chk({tag, " flags"}, {overflow_out, underflow_out, zero_out, special_out},
        {v.e_ovf, v.e_unf, v.e_zf, v.e_spf});
    chk({tag, " shift_en_cnt"}, n_se, v.e_se);
    chk({tag, " add_en_cnt"}, n_ae, v.e_se);
    chk({tag, " norm_right_cnt"}, n_r, v.e_right);
    chk({tag, " norm_left_cnt"}, n_l, v.e_left);
    chk({tag, " ready_after"}, ready_out, 1);
  endtask

  vec_t tbl[14];
  vec_t rv;
  int   seen_done;

  initial begin
    tbl[0]  = mk(9'h003, 130, 0, 0, 0, 0,  1, 3,  130, 0, 0, 0, 0, 5,  0, 0,  1);
    tbl[1]  = mk(9'h1D8, 140, 0, 0, 0, 0,  0, 25, 140, 0, 0, 0, 0, 5,  0, 0,  1);
    tbl[2]  = mk(9'h000, 200, 0, 1, 0, 0,  1, 0,  201, 0, 0, 0, 0, 5,  1, 0,  1);
    tbl[3]  = mk(9'h002, 254, 0, 1, 0, 0,  1, 2,  255, 1, 0, 0, 0, 5,  0, 0,  1);
    tbl[4]  = mk(9'h001, 127, 1, 0, 0, 3,  1, 1,  124, 0, 0, 0, 0, 8,  0, 3,  1);
    tbl[5]  = mk(9'h1FE, 2,   0, 0, 0, 99, 0, 2,  1,   0, 1, 0, 0, 6,  0, 1,  1);
    tbl[6]  = mk(9'h005, 255, 0, 0, 0, 0,  1, 5,  255, 0, 0, 0, 1, 2,  0, 0,  0);
    tbl[7]  = mk(9'h1FF, 90,  1, 0, 1, 0,  0, 1,  0,   0, 0, 1, 0, 5,  0, 0,  1);
    tbl[8]  = mk(9'h000, 127, 0, 0, 0, 99, 1, 0,  103, 0, 0, 0, 0, 29, 0, 24, 1);
    tbl[9]  = mk(9'h100, 10,  0, 0, 0, 0,  0, 25, 10,  0, 0, 0, 0, 5,  0, 0,  1);
    tbl[10] = mk(9'h0FF, 60,  0, 0, 0, 0,  1, 25, 60,  0, 0, 0, 0, 5,  0, 0,  1);
    tbl[11] = mk(9'h019, 60,  0, 0, 0, 0,  1, 25, 60,  0, 0, 0, 0, 5,  0, 0,  1);
    tbl[12] = mk(9'h018, 60,  0, 0, 0, 0,  1, 24, 60,  0, 0, 0, 0, 5,  0, 0,  1);
    tbl[13] = mk(9'h1E8, 60,  0, 0, 0, 0,  0, 24, 60,  0, 0, 0, 0, 5,  0, 0,  1);

    rst_n_in = 0; start_in = 1; exp_diff_in = 9'h003; bigger_exponent_in = 8'd100;
    signs_differ_in = 1; sum_carry_in = 1; sum_msb_in = 0; sum_zero_in = 0;
    seen_done = 0;
    repeat (5) begin
      @(negedge clk_in);
      seen_done += int'(done_out);
    end
    chk("reset ready", ready_out, 1);
    chk("reset outputs", all_outs(), 0);
    chk("reset no_done", seen_done, 0);
    @(posedge clk_in); #1;
    start_in = 0; sum_carry_in = 0;
    @(posedge clk_in); #1;
    rst_n_in = 1;
    repeat (2) @(negedge clk_in);
    chk("post_reset idle", {ready_out, all_outs()}, {1'b1, 29'd0});

    for (int i = 0; i < 14; i++) run_op(tbl[i], i == 4, $sformatf("vec%0d", i));

    // Reset while in NORM: back to IDLE at once, nothing left behind.
    run_op(tbl[3], 0, "pre_abort");
    @(posedge clk_in); #1;
    exp_diff_in = 9'h004; bigger_exponent_in = 8'd127; signs_differ_in = 1;
    sum_carry_in = 0; sum_msb_in = 0; sum_zero_in = 0; start_in = 1;
    @(posedge clk_in); #1;
    start_in = 0;
    repeat (5) @(posedge clk_in);
    #1;
    chk("abort in_progress", ready_out, 0);
    rst_n_in = 0;
    #1;
    chk("abort ready", ready_out, 1);
    chk("abort outputs", all_outs(), 0);
    seen_done = 0;
    repeat (2) begin
      @(negedge clk_in);
      seen_done += int'(done_out);
    end
    @(posedge clk_in); #1;
    rst_n_in = 1;
    repeat (4) begin
      @(negedge clk_in);
      seen_done += int'(done_out);
    end
    chk("abort no_done", seen_done, 0);
    chk("abort idle", {ready_out, all_outs()}, {1'b1, 29'd0});

    for (int n = 0; n < 200; n++) begin
      int mode, kind;
      rv = tbl[0];
      rv.diff  = 9'($urandom);
      rv.sdiff = 1'($urandom);
      mode = $urandom_range(0, 19);
      if (mode == 0) rv.big = 8'd255;
      else if (mode == 1) rv.big = 8'd254;
      else if (mode == 2) rv.big = 8'($urandom_range(1, 4));
      else rv.big = 8'($urandom_range(1, 254));
      kind = $urandom_range(0, 5);
      rv.zero  = (kind == 0);
      rv.carry = (kind == 1) || (kind == 2 && $urandom_range(0, 1) == 1);
      rv.n_low = $urandom_range(0, 30);
      run_op(model(rv), n % 7 == 0, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
